vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_SYNC 96, hsync width in clocks; H_BACK 48, h back porch; H_ACT 640, active pixels per line; H_FRONT 16, h front porch; V_SYNC 2, vsync width in lines; V_BACK 33, v back porch; V_ACT 480, active lines; V_FRONT 10, v front porch.
REQ-002 CLK  input  1  pixel clock; all logic on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 ENABLE  input  1  high = timing runs; low = freeze.
REQ-005 R_IN, G_IN, B_IN  input  8 each  pixel data, sampled in the cycle VGA_REQ is high.
REQ-006 VGA_H_CNT, VGA_V_CNT  output  13 each  horizontal and vertical counters, registered.
REQ-007 VGA_HS, VGA_VS  output  1 each  syncs, active-low, registered.
REQ-008 VGA_BLANK_N  output  1  high during active video.
REQ-009 VGA_REQ  output  1  pixel request, leads active video by one clock.
REQ-010 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel output.
REQ-011 FRAME_START  output  1  one-clock pulse at each wrap to (0,0).

Function
REQ-012 Derived constants SHALL be H_TOTAL=H_SYNC+H_BACK+H_ACT+H_FRONT (800), V_TOTAL (525), X_START=H_SYNC+H_BACK (144), Y_START=V_SYNC+V_BACK (35).
REQ-013 VGA_H_CNT SHALL increment by 1 per enabled clock and wrap from H_TOTAL-1 to 0.
REQ-014 VGA_V_CNT SHALL increment only on the clock where H wraps, and SHALL wrap from V_TOTAL-1 to 0 on the same clock in which H wraps.
REQ-015 VGA_HS SHALL be 0 exactly when VGA_H_CNT < H_SYNC, and VGA_VS SHALL be 0 exactly when VGA_V_CNT < V_SYNC, both in the same cycle as the counter value (computed from next-count and registered).
REQ-016 VGA_BLANK_N SHALL be 1 exactly when X_START <= H_CNT < X_START+H_ACT and Y_START <= V_CNT < Y_START+V_ACT.
REQ-017 VGA_REQ SHALL be 1 exactly when X_START-1 <= H_CNT < X_START+H_ACT-1 with V_CNT in the active range.
REQ-018 RGB data sampled at an edge where VGA_REQ=1 SHALL appear on VGA_R/G/B in the following cycle, in which BLANK_N=1 (one-clock latency).
REQ-019 VGA_R/G/B SHALL be 0 in every cycle where VGA_BLANK_N=0.
REQ-020 FRAME_START SHALL be 1 for one cycle when the counters transition from (H_TOTAL-1, V_TOTAL-1) to (0,0), and SHALL NOT pulse on reset release.
REQ-021 With ENABLE=0: counters, HS and VS SHALL hold; VGA_REQ, FRAME_START and RGB SHALL be 0; BLANK_N SHALL be 0.
REQ-022 When ENABLE returns to 1, counting SHALL resume from the held value on the next edge with no skipped count.
REQ-023 Counter width SHALL be 13 bits and SHALL cover all totals up to 8191; totals greater than 8191 are unsupported.

Reset
REQ-024 When RST_N=0, the block SHALL asynchronously set H_CNT=0, V_CNT=0, HS=0, VS=0, BLANK_N=0, REQ=0, FRAME_START=0, RGB=0.
REQ-025 The first enabled edge after release SHALL produce H_CNT=1.
REQ-026 Reset mid-line or mid-frame SHALL abort the frame, with no FRAME_START pulse.

Configuration
REQ-027 With macro VGA_TEST_PATTERN_EN defined, R_IN/G_IN/B_IN SHALL be ignored and output pixels SHALL be eight vertical colour bars of H_ACT/8 pixels each, in the order white, yellow, cyan, green, magenta, red, blue, black (components 0 or 255), with latency and blanking unchanged.
REQ-028 Without VGA_TEST_PATTERN_EN, pixels SHALL come from R_IN/G_IN/B_IN per REQ-018, and no pattern logic SHALL be present.

Verification
REQ-029 Free-run 2 frames from reset -> HS low 96 of every 800 clocks, VS low for 1600 clocks per 420000, and FRAME_START pulses exactly once per 420000 clocks.
REQ-030 Drive R_IN=8'hAA at the edge where REQ=1 and H_CNT=143, V_CNT=35 -> the next cycle shows H_CNT=144, BLANK_N=1, VGA_R=8'hAA.
REQ-031 Hold R_IN=8'hFF constantly -> VGA_R=0 whenever BLANK_N=0, including at H_CNT=784 and V_CNT=520.
REQ-032 Deassert ENABLE for 10 clocks at H_CNT=300 -> counters hold at 300, RGB=0, and H_CNT=301 on the first enabled edge.
REQ-033 Assert RST_N=0 asynchronously at H_CNT=500, V_CNT=200 -> all outputs are at reset values before the next edge, with no FRAME_START pulse.
REQ-034 With VGA_TEST_PATTERN_EN defined, at V_CNT=100 -> H_CNT=144 gives RGB=(255,255,255), H_CNT=224 gives (255,255,0), and H_CNT=704 gives (0,0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with one-clock pixel request and registered RGB output.
// Ports: CLK pixel clock; RST_N async active-low reset; ENABLE runs (1) or freezes (0) the raster;
//        R_IN/G_IN/B_IN pixel data sampled while VGA_REQ is high; VGA_H_CNT/VGA_V_CNT raster position;
//        VGA_HS/VGA_VS active-low syncs; VGA_BLANK_N active video; VGA_REQ pixel request one clock
//        ahead of active video; VGA_R/G/B registered pixels; FRAME_START one-clock pulse on wrap to (0,0).
// Build option: define VGA_TEST_PATTERN_EN to replace the RGB inputs with eight vertical colour bars.
module vga_timing_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_ACT   = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ENABLE,
    input  logic [7:0]  R_IN,
    input  logic [7:0]  G_IN,
    input  logic [7:0]  B_IN,
    output logic [12:0] VGA_H_CNT,
    output logic [12:0] VGA_V_CNT,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_REQ,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        FRAME_START
);
    localparam logic [12:0] H_TOTAL = 13'(H_SYNC + H_BACK + H_ACT + H_FRONT);
    localparam logic [12:0] V_TOTAL = 13'(V_SYNC + V_BACK + V_ACT + V_FRONT);
    localparam logic [12:0] X_START = 13'(H_SYNC + H_BACK);
    localparam logic [12:0] X_END   = 13'(H_SYNC + H_BACK + H_ACT);
    localparam logic [12:0] Y_START = 13'(V_SYNC + V_BACK);
    localparam logic [12:0] Y_END   = 13'(V_SYNC + V_BACK + V_ACT);
    localparam logic [12:0] HS_END  = 13'(H_SYNC);
    localparam logic [12:0] VS_END  = 13'(V_SYNC);

    logic        h_wrap;
    logic        v_wrap;
    logic [12:0] h_nxt;
    logic [12:0] v_nxt;
    logic        v_act_nxt;
    logic [7:0]  r_pix;
    logic [7:0]  g_pix;
    logic [7:0]  b_pix;

    // Every registered output is derived from the next count so it lines up with the counter it accompanies.
    always_comb begin
        h_wrap    = VGA_H_CNT == H_TOTAL - 13'd1;
        v_wrap    = VGA_V_CNT == V_TOTAL - 13'd1;
        h_nxt     = h_wrap ? '0 : VGA_H_CNT + 13'd1;
        v_nxt     = h_wrap ? (v_wrap ? '0 : VGA_V_CNT + 13'd1) : VGA_V_CNT;
        v_act_nxt = v_nxt >= Y_START && v_nxt < Y_END;
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [12:0] BAR_W = 13'(H_ACT / 8);
    logic [2:0] bar;
    wire unused_rgb_in = ^{R_IN, G_IN, B_IN};
    // Pixel requested now is shown at H_CNT+1, so the bar index is taken relative to X_START-1.
    // Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar   = 3'((VGA_H_CNT - (X_START - 13'd1)) / BAR_W);
        r_pix = {8{~bar[1]}};
        g_pix = {8{~bar[2]}};
        b_pix = {8{~bar[0]}};
    end
`else
    assign r_pix = R_IN;
    assign g_pix = G_IN;
    assign b_pix = B_IN;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            VGA_H_CNT   <= '0;
            VGA_V_CNT   <= '0;
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_BLANK_N <= 1'b0;
            VGA_REQ     <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            FRAME_START <= 1'b0;
        end else if (ENABLE) begin
            VGA_H_CNT   <= h_nxt;
            VGA_V_CNT   <= v_nxt;
            VGA_HS      <= h_nxt >= HS_END;
            VGA_VS      <= v_nxt >= VS_END;
            VGA_BLANK_N <= h_nxt >= X_START && h_nxt < X_END && v_act_nxt;
            VGA_REQ     <= h_nxt >= X_START - 13'd1 && h_nxt < X_END - 13'd1 && v_act_nxt;
            VGA_R       <= VGA_REQ ? r_pix : '0;
            VGA_G       <= VGA_REQ ? g_pix : '0;
            VGA_B       <= VGA_REQ ? b_pix : '0;
            FRAME_START <= h_wrap && v_wrap;
        end else begin
            VGA_BLANK_N <= 1'b0;
            VGA_REQ     <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            FRAME_START <= 1'b0;
        end
    end
endmodule
